// File: rtl/ika9958_cpu_regwr_if.sv
// CPU-port bundle for the IKA9958 register write decoder: raw port accesses in,
// register/palette/VRAM-address write strobes and pointer shadows out.
interface ika9958_cpu_regwr_if;
    logic        wr;
    logic        rd;
    logic [1:0]  port;
    logic [7:0]  data;
    logic        reg_we;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [8:0]  pal_data;
    logic        vaddr_we;
    logic [13:0] vaddr;
    logic        vaddr_rd;
    logic [7:0]  r16;
    logic [7:0]  r17;

    // Handshake: wr/rd are single-cycle strobes with port/data valid alongside;
    // every *_we output is a one-cycle pulse with its address/data valid in that
    // same cycle and held until the next pulse of the same kind. No back-pressure.
    modport master (
        output wr, rd, port, data,
        input  reg_we, reg_addr, reg_data, pal_we, pal_idx, pal_data,
        input  vaddr_we, vaddr, vaddr_rd, r16, r17
    );

    modport slave (
        input  wr, rd, port, data,
        output reg_we, reg_addr, reg_data, pal_we, pal_idx, pal_data,
        output vaddr_we, vaddr, vaddr_rd, r16, r17
    );
endinterface

// File: rtl/ika9958_cpu_regwr.sv
// CPU-side write decoder for the IKA9958: turns port 1/2/3 write sequences into
// registered single-cycle register, palette and VRAM-address write strobes.
module ika9958_cpu_regwr (
    input  logic        i_CLK,
    input  logic        i_RST_n,
    input  logic        i_WR,
    input  logic        i_RD,
    input  logic [1:0]  i_PORT,
    input  logic [7:0]  i_DATA,
    output logic        o_REG_WE,
    output logic [5:0]  o_REG_ADDR,
    output logic [7:0]  o_REG_DATA,
    output logic        o_PAL_WE,
    output logic [3:0]  o_PAL_IDX,
    output logic [8:0]  o_PAL_DATA,
    output logic        o_VADDR_WE,
    output logic [13:0] o_VADDR,
    output logic        o_VADDR_RD,
    output logic [7:0]  o_R16,
    output logic [7:0]  o_R17
);

    typedef enum logic {P1_IDLE = 1'b0, P1_WAIT = 1'b1} p1_state_t;
    typedef enum logic {P2_IDLE = 1'b0, P2_WAIT = 1'b1} p2_state_t;

    p1_state_t   r_p1_state, w_p1_next;
    p2_state_t   r_p2_state, w_p2_next;
    logic [7:0]  r_l1, w_l1_next;
    logic [2:0]  r_pal_r, w_pal_r_next;
    logic [2:0]  r_pal_b, w_pal_b_next;
    logic [7:0]  r_r16, w_r16_next;
    logic [7:0]  r_r17, w_r17_next;

    logic        w_reg_we;
    logic [5:0]  w_reg_addr;
    logic [7:0]  w_reg_data;
    logic        w_pal_we;
    logic [3:0]  w_pal_idx;
    logic [8:0]  w_pal_data;
    logic        w_vaddr_we;
    logic [13:0] w_vaddr;
    logic        w_vaddr_rd;

    always_comb begin
        w_p1_next    = r_p1_state;
        w_p2_next    = r_p2_state;
        w_l1_next    = r_l1;
        w_pal_r_next = r_pal_r;
        w_pal_b_next = r_pal_b;
        w_r16_next   = r_r16;
        w_r17_next   = r_r17;
        w_reg_we     = 1'b0;
        w_reg_addr   = o_REG_ADDR;
        w_reg_data   = o_REG_DATA;
        w_pal_we     = 1'b0;
        w_pal_idx    = o_PAL_IDX;
        w_pal_data   = o_PAL_DATA;
        w_vaddr_we   = 1'b0;
        w_vaddr      = o_VADDR;
        w_vaddr_rd   = o_VADDR_RD;

        // A write takes priority over a coincident read.
        if (i_WR) begin
            case (i_PORT)
                2'd1: begin
                    if (r_p1_state == P1_IDLE) begin
                        w_l1_next = i_DATA;
                        w_p1_next = P1_WAIT;
                    end else begin
                        if (i_DATA[7]) begin
                            w_reg_we   = 1'b1;
                            w_reg_addr = i_DATA[5:0];
                            w_reg_data = r_l1;
                        end else begin
                            w_vaddr_we = 1'b1;
                            w_vaddr    = {i_DATA[5:0], r_l1};
                            w_vaddr_rd = ~i_DATA[6];
                        end
                        w_p1_next = P1_IDLE;
                    end
                end
                2'd2: begin
                    if (r_p2_state == P2_IDLE) begin
                        w_pal_r_next = i_DATA[6:4];
                        w_pal_b_next = i_DATA[2:0];
                        w_p2_next    = P2_WAIT;
                    end else begin
                        w_pal_we   = 1'b1;
                        w_pal_idx  = r_r16[3:0];
                        w_pal_data = {r_pal_r, i_DATA[2:0], r_pal_b};
                        w_r16_next = {r_r16[7:4], r_r16[3:0] + 4'd1};
                        w_p2_next  = P2_IDLE;
                    end
                end
                2'd3: begin
                    // Indirect writes can never target R#17 itself.
                    if (r_r17[5:0] != 6'd17) begin
                        w_reg_we   = 1'b1;
                        w_reg_addr = r_r17[5:0];
                        w_reg_data = i_DATA;
                    end
                    if (!r_r17[7]) begin
                        w_r17_next = {r_r17[7:6], r_r17[5:0] + 6'd1};
                    end
                end
                default: ;
            endcase
        end else if (i_RD && (i_PORT == 2'd1)) begin
            w_p1_next = P1_IDLE;
        end

        if (w_reg_we && (w_reg_addr == 6'd16)) begin
            w_r16_next = w_reg_data;
            w_p2_next  = P2_IDLE;
        end
        if (w_reg_we && (w_reg_addr == 6'd17)) begin
            w_r17_next = w_reg_data;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_p1_state <= P1_IDLE;
            r_p2_state <= P2_IDLE;
            r_l1       <= 8'd0;
            r_pal_r    <= 3'd0;
            r_pal_b    <= 3'd0;
            r_r16      <= 8'd0;
            r_r17      <= 8'd0;
            o_REG_WE   <= 1'b0;
            o_REG_ADDR <= 6'd0;
            o_REG_DATA <= 8'd0;
            o_PAL_WE   <= 1'b0;
            o_PAL_IDX  <= 4'd0;
            o_PAL_DATA <= 9'd0;
            o_VADDR_WE <= 1'b0;
            o_VADDR    <= 14'd0;
            o_VADDR_RD <= 1'b0;
        end else begin
            r_p1_state <= w_p1_next;
            r_p2_state <= w_p2_next;
            r_l1       <= w_l1_next;
            r_pal_r    <= w_pal_r_next;
            r_pal_b    <= w_pal_b_next;
            r_r16      <= w_r16_next;
            r_r17      <= w_r17_next;
            o_REG_WE   <= w_reg_we;
            o_REG_ADDR <= w_reg_addr;
            o_REG_DATA <= w_reg_data;
            o_PAL_WE   <= w_pal_we;
            o_PAL_IDX  <= w_pal_idx;
            o_PAL_DATA <= w_pal_data;
            o_VADDR_WE <= w_vaddr_we;
            o_VADDR    <= w_vaddr;
            o_VADDR_RD <= w_vaddr_rd;
        end
    end

    assign o_R16 = r_r16;
    assign o_R17 = r_r17;

endmodule

// File: doc/ika9958_cpu_regwr.md
# ika9958_cpu_regwr

CPU-side write decoder for the IKA9958 register set. Converts raw CPU port accesses into single-cycle write strobes for the 64×8 register storage and the 16-entry palette. It implements the V9958 two-byte port-1 sequence, port-2 palette writes, and port-3 indirect writes with R#17 auto-increment. It sits between the bus synchroniser and the register block, and is the only writer of register contents.

## Interface
- No parameters.
- `i_CLK` in 1: master clock; all state changes on its rising edge.
- `i_RST_n` in 1: reset, asynchronous, active-low.
- `i_WR` in 1: one-cycle CPU write strobe, already synchronised to `i_CLK`.
- `i_RD` in 1: one-cycle CPU read strobe, already synchronised to `i_CLK`.
- `i_PORT` in 2: port select (0 VRAM data, 1 control/status, 2 palette, 3 indirect).
- `i_DATA` in 8: CPU write data; valid when `i_WR`=1.
- `o_REG_WE` out 1: register write pulse.
- `o_REG_ADDR` out 6: register number for the write.
- `o_REG_DATA` out 8: register value for the write.
- `o_PAL_WE` out 1: palette write pulse.
- `o_PAL_IDX` out 4: palette entry index.
- `o_PAL_DATA` out 9: palette colour as {R[2:0],G[2:0],B[2:0]}.
- `o_VADDR_WE` out 1: VRAM address-setup pulse.
- `o_VADDR` out 14: VRAM address, {hi[5:0], lo[7:0]}.
- `o_VADDR_RD` out 1: 1 = read setup (`i_DATA[6]`=0), 0 = write setup.
- `o_R16` out 8: shadow of R#16, the palette pointer.
- `o_R17` out 8: shadow of R#17, the indirect pointer.

## Operation
- Port-1 state machine has two states.
  - P1_IDLE, on port-1 write: latch `i_DATA` → L1, go to P1_WAIT.
  - P1_WAIT, on port-1 write with `i_DATA[7]`=1: register write {ADDR=`i_DATA[5:0]`, DATA=L1}. Go to P1_IDLE.
  - P1_WAIT, on port-1 write with `i_DATA[7]`=0: VRAM setup {`o_VADDR`={`i_DATA[5:0]`,L1}, `o_VADDR_RD`=~`i_DATA[6]`}. Go to P1_IDLE.
  - Port-1 read in either state: go to P1_IDLE (status read resets the flag). L1 is kept.
- Port-2 state machine has two states.
  - P2_IDLE, on port-2 write: latch {R=`i_DATA[6:4]`, B=`i_DATA[2:0]`}, go to P2_WAIT.
  - P2_WAIT, on port-2 write: palette write {IDX=R16[3:0], DATA={R,`i_DATA[2:0]`,B}}. Then R16[3:0] += 1 (15 wraps to 0), R16[7:4] unchanged. Go to P2_IDLE.
- Port-3 write:
  - Target = R17[5:0].
  - If target = 17: no strobe is emitted (ignored).
  - Otherwise: register write {ADDR=target, DATA=`i_DATA`}.
  - In both cases, if R17[7]=0, R17[5:0] += 1 (63 wraps to 0). R17[7:6] unchanged.
- Shadows:
  - Any register write to address 16 loads R16 and forces P2_IDLE.
  - Any register write to address 17 loads R17.
  - Auto-increments update the shadows only; they emit no `o_REG_WE`.
- Port-0 accesses are ignored by this block and leave all state unchanged.
- Simultaneous `i_WR` and `i_RD`: the write is processed and the read is ignored.

## Timing
- All outputs are registered.
- Strobes (`o_REG_WE`, `o_PAL_WE`, `o_VADDR_WE`) pulse high exactly one cycle, in the cycle after the qualifying `i_WR`. Latency is 1 cycle.
- Address/data outputs update together with their strobe and hold until the next strobe of the same kind.
- Shadows and FSM states update on the same edge as the strobe. A back-to-back `i_WR` on the next cycle sees the updated R16/R17.
- Strobe rate is at most one per cycle per output. With `i_WR` every cycle, each qualifying access still yields its own pulse.
- Reset values (asynchronous, while `i_RST_n`=0):
  - All outputs 0.
  - R16 = R17 = 0, L1 = 0, palette latch 0.
  - Both FSMs in IDLE.
- Reset during a sequence: a half-completed sequence is discarded and no strobe is produced.

## Test plan
- Port 1: write 0x5A, then 0x87 → one `o_REG_WE` with ADDR=7, DATA=0x5A, one cycle after the second write. Write 0x34 then 0x52 → `o_VADDR_WE`, `o_VADDR`=0x1234, `o_VADDR_RD`=0.
- Port 1: write 0x11, read port 1, write 0x22, write 0x81 → REG write ADDR=1, DATA=0x22. The first byte is discarded.
- Port 2: R16=0x0F via port 1. Write 0x73, then 0x05 → PAL_WE IDX=15, DATA={3'd7,3'd5,3'd3}=0x1EB, and R16 becomes 0x00.
- Port 3 increment:
  - R17=0x3E; write 0xAA, then 0xBB → writes to R62 and R63, and R17 wraps to 0x00.
  - R17=0x91 (auto-increment off); write 0x3C twice → two writes to R17[5:0]=17.
  - Both are ignored (no strobe), and R17 stays 0x91.
- Assert `i_RST_n`=0 after the first port-1 byte, release, then write 0x85 → all outputs 0 during reset, and no REG write for 0x85 (it becomes a new first byte).
- Same-cycle `i_WR` (port 1, 0x80) and `i_RD` while in P1_WAIT → REG write to R0 with the latched data.
